// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor
//   Multi-cycle subtractor computing a - b - bin over WIDTH bits, DIGIT bits per
//   clock, LSB digit first. The borrow ripples between digits through a register,
//   so the datapath is only DIGIT full-subtractor cells wide.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only when not busy (IDLE or DONE)
//   a, b   minuend / subtrahend, captured on the accepting edge
//   bin    borrow-in, captured on the accepting edge
//   busy   high while digits are being processed
//   done   one-cycle pulse, results valid in the same cycle
//   diff   (a - b - bin) mod 2^WIDTH
//   bout   borrow out of the MSB digit
//   zero   diff == 0
//   ovf    signed overflow: (a[msb]^b[msb]) & (diff[msb]^a[msb])
module digit_serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    // Storage for the digits already produced; the final digit goes straight to diff.
    localparam int unsigned PART_W = (WIDTH > DIGIT) ? (WIDTH - DIGIT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               borrow;
    logic [CNT_W-1:0]   cnt;
    logic [PART_W-1:0]  part;
    logic               a_msb;
    logic               b_msb;

    logic [DIGIT-1:0]   dig;
    logic               dig_bout;
    logic [WIDTH-1:0]   diff_next;
    logic [PART_W-1:0]  part_next;

    // One digit of full-subtractor cells, chained through the registered borrow.
    always_comb begin : digit_sub
        logic br;
        br  = borrow;
        dig = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dig[i] = a_sh[i] ^ b_sh[i] ^ br;
            br     = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & br);
        end
        dig_bout = br;
    end

    // New digit enters at the MSB end; after N shifts the whole result is aligned.
    generate
        if (WIDTH > DIGIT) begin : g_shift
            assign diff_next = {dig, part};
            assign part_next = diff_next[WIDTH-1:DIGIT];
        end else begin : g_single
            assign diff_next = dig;
            assign part_next = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            a_sh   <= '0;
            b_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            part   <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        part   <= '0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        busy   <= 1'b1;
                        state  <= StRun;
                    end else begin
                        state <= StIdle;
                    end
                end
                StRun: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    borrow <= dig_bout;
                    part   <= part_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        // Results are published only here, never mid-operation.
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= diff_next;
                        bout  <= dig_bout;
                        zero  <= (diff_next == '0);
                        ovf   <= (a_msb ^ b_msb) & (diff_next[WIDTH-1] ^ a_msb);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Bench for digit_serial_subtractor: unit 0 is WIDTH=8/DIGIT=1, unit 1 is
// WIDTH=8/DIGIT=4. Table vectors, handshake/reset sequences, random ops.
module tb_digit_serial_subtractor;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       start, bin, busy, done, bout, zero, ovf;
    logic [1:0][7:0]  a, b, diff;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    digit_serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a[0]), .b(b[0]), .bin(bin[0]),
        .busy(busy[0]), .done(done[0]), .diff(diff[0]), .bout(bout[0]), .zero(zero[0]),
        .ovf(ovf[0])
    );

    digit_serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a[1]), .b(b[1]), .bin(bin[1]),
        .busy(busy[1]), .done(done[1]), .diff(diff[1]), .bout(bout[1]), .zero(zero[1]),
        .ovf(ovf[1])
    );

    typedef struct {
        int         u;
        logic [7:0] av;
        logic [7:0] bv;
        logic       binv;
        logic [7:0] ed;
        logic       eb;
        logic       ez;
        logic       eo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        else passed++;
    endtask

    // Reference: plain integer arithmetic; ovf from the defined sign formula.
    function automatic void model(input logic [7:0] av, input logic [7:0] bv, input logic binv,
                                  output logic [7:0] d, output logic bo, output logic z,
                                  output logic ov);
        int r;
        r  = int'(av) - int'(bv) - int'(binv);
        d  = r[7:0];
        bo = (r < 0);
        z  = (d == 8'h00);
        ov = (av[7] ^ bv[7]) & (d[7] ^ av[7]);
    endfunction

    task automatic launch(input int u, input logic [7:0] av, input logic [7:0] bv,
                          input logic binv);
        start[u] = 1'b1;
        a[u]     = av;
        b[u]     = bv;
        bin[u]   = binv;
    endtask

    // Waits (bounded) for done, checking latency, busy length and results.
    task automatic wait_done(input int u, input string name, input logic [7:0] ed,
                             input logic eb, input logic ez, input logic eo,
                             input int repulse_at);
        int n;
        int lat;
        int bc;
        n   = (u == 0) ? 8 : 2;
        lat = 0;
        bc  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Operands must already be captured; scramble them.
                start[u] = 1'b0;
                a[u]     = 8'($urandom);
                b[u]     = 8'($urandom);
                bin[u]   = 1'($urandom);
            end
            if (repulse_at != 0 && c == repulse_at) begin
                start[u] = 1'b1;
                a[u]     = ~ed;
                b[u]     = ed;
            end
            if (repulse_at != 0 && c == repulse_at + 1) start[u] = 1'b0;
            if (done[u]) begin
                lat = c;
                break;
            end
            if (busy[u]) bc++;
        end
        chk({name, " latency"}, lat, n + 1);
        chk({name, " busy_cycles"}, bc, n);
        chk({name, " diff"}, diff[u], ed);
        chk({name, " bout"}, bout[u], eb);
        chk({name, " zero"}, zero[u], ez);
        chk({name, " ovf"}, ovf[u], eo);
    endtask

    task automatic after_done(input int u, input string name, input logic [7:0] ed);
        @(negedge clk);
        chk({name, " done_pulse_width"}, done[u], 1'b0);
        chk({name, " diff_hold"}, diff[u], ed);
    endtask

    initial begin
        logic [7:0] md;
        logic       mb, mz, mo;
        int         dcount;

        vecs[0] = '{0, 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{0, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{0, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1, 8'hA3, 8'h5C, 1'b0, 8'h47, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        start = '0;
        bin   = '0;
        a     = '0;
        b     = '0;
        #12;
        for (int u = 0; u < 2; u++) begin
            chk("reset busy", busy[u], 1'b0);
            chk("reset done", done[u], 1'b0);
            chk("reset diff", diff[u], 8'h00);
            chk("reset flags", {bout[u], zero[u], ovf[u]}, 3'b000);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            launch(vecs[i].u, vecs[i].av, vecs[i].bv, vecs[i].binv);
            wait_done(vecs[i].u, $sformatf("vec%0d", i), vecs[i].ed, vecs[i].eb, vecs[i].ez,
                      vecs[i].eo, 0);
            after_done(vecs[i].u, $sformatf("vec%0d", i), vecs[i].ed);
        end

        // start re-pulsed mid-RUN must be ignored.
        @(negedge clk);
        launch(0, 8'h35, 8'h12, 1'b0);
        wait_done(0, "repulse", 8'h23, 1'b0, 1'b0, 1'b0, 3);
        after_done(0, "repulse", 8'h23);

        // start high in the DONE cycle chains straight into the next op.
        @(negedge clk);
        launch(0, 8'h50, 8'h21, 1'b0);
        wait_done(0, "b2b_first", 8'h2F, 1'b0, 1'b0, 1'b0, 0);
        launch(0, 8'h21, 8'h50, 1'b1);
        wait_done(0, "b2b_second", 8'hD0, 1'b1, 1'b0, 1'b0, 0);
        after_done(0, "b2b_second", 8'hD0);

        // Reset in the 4th RUN cycle: outputs clear at once, no done follows.
        @(negedge clk);
        launch(0, 8'h77, 8'h11, 1'b0);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy_before", busy[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy[0], 1'b0);
        chk("abort done", done[0], 1'b0);
        chk("abort diff", diff[0], 8'h00);
        chk("abort flags", {bout[0], zero[0], ovf[0]}, 3'b000);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done[0] || busy[0]) dcount++;
        end
        chk("abort no_done", dcount, 0);
        @(negedge clk);
        model(8'h9C, 8'h3D, 1'b1, md, mb, mz, mo);
        launch(0, 8'h9C, 8'h3D, 1'b1);
        wait_done(0, "post_abort", md, mb, mz, mo, 0);
        after_done(0, "post_abort", md);

        // Random operations on both units against the arithmetic model.
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 40; i++) begin
                logic [7:0] ra, rb;
                logic       rc;
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                if (i == 0) begin
                    ra = 8'h00;
                    rb = 8'hFF;
                    rc = 1'b1;
                end
                model(ra, rb, rc, md, mb, mz, mo);
                @(negedge clk);
                launch(u, ra, rb, rc);
                wait_done(u, $sformatf("rand_u%0d_%0d", u, i), md, mb, mz, mo, 0);
                after_done(u, $sformatf("rand_u%0d_%0d", u, i), md);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
